// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two width conversion between write and read sides.
// Storage is kept in narrow-width units; each side moves ratio units (or one) per access.
module sync_fifo #(
  parameter int    INPUT_WIDTH  = 16,
  parameter int    OUTPUT_WIDTH = 16,
  parameter int    WR_DEPTH     = 16,
  parameter int    RD_DEPTH     = 16,
  parameter string MODE         = "FWFT",
  parameter string DIRECTION    = "LSB"
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [INPUT_WIDTH-1:0]        din,
  input  logic                          rd_en,
  output logic                          valid,
  output logic [OUTPUT_WIDTH-1:0]       dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(WR_DEPTH):0]     wr_data_count,
  output logic [$clog2(RD_DEPTH):0]     rd_data_count,
  output logic [$clog2(WR_DEPTH):0]     wr_data_space,
  output logic [$clog2(RD_DEPTH):0]     rd_data_space
);

  localparam int NW    = (INPUT_WIDTH < OUTPUT_WIDTH) ? INPUT_WIDTH : OUTPUT_WIDTH;
  localparam int WRU   = INPUT_WIDTH / NW;
  localparam int RDU   = OUTPUT_WIDTH / NW;
  localparam int UNITS = WR_DEPTH * WRU;
  localparam int PW    = $clog2(UNITS);
  localparam int CW    = PW + 1;
  localparam int WCW   = $clog2(WR_DEPTH) + 1;
  localparam int RCW   = $clog2(RD_DEPTH) + 1;
  localparam int WRSH  = $clog2(WRU);
  localparam int RDSH  = $clog2(RDU);
  localparam bit IS_FWFT = (MODE == "FWFT");
  localparam bit IS_LSB  = (DIRECTION == "LSB");

  logic [NW-1:0]           r_mem [UNITS];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_cnt;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic [CW-1:0]           w_cnt_up;
  logic [WCW-1:0]          w_wr_cnt;
  logic [RCW-1:0]          w_rd_cnt;
  logic [OUTPUT_WIDTH-1:0] w_head;

  // Unit count rounded up to input words: a partially drained wide slot stays occupied.
  assign w_cnt_up = r_cnt + CW'(WRU - 1);
  assign w_wr_cnt = WCW'(w_cnt_up >> WRSH);
  assign w_rd_cnt = RCW'(r_cnt >> RDSH);
  assign w_full   = (w_wr_cnt == WCW'(WR_DEPTH));
  assign w_empty  = (w_rd_cnt == '0);
  assign w_wr_acc = wr_en & ~w_full;
  assign w_rd_acc = rd_en & ~w_empty;

  assign full          = w_full;
  assign empty         = w_empty;
  assign wr_data_count = w_wr_cnt;
  assign rd_data_count = w_rd_cnt;
  assign wr_data_space = WCW'(WR_DEPTH) - w_wr_cnt;
  assign rd_data_space = RCW'(RD_DEPTH) - w_rd_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(WRU);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(RDU);
      r_cnt <= r_cnt + (w_wr_acc ? CW'(WRU) : CW'(0)) - (w_rd_acc ? CW'(RDU) : CW'(0));
    end
  end

  // Unit k of a wide write is the k-th sub-word to be read out.
  always_ff @(posedge clock) begin
    if (w_wr_acc) begin
      for (int k = 0; k < WRU; k++) begin
        r_mem[r_wr_ptr + PW'(k)] <= din[(IS_LSB ? k : WRU - 1 - k) * NW +: NW];
      end
    end
  end

  always_comb begin
    w_head = '0;
    for (int k = 0; k < RDU; k++) begin
      w_head[(IS_LSB ? k : RDU - 1 - k) * NW +: NW] = r_mem[r_rd_ptr + PW'(k)];
    end
  end

  if (IS_FWFT) begin : g_fwft
    assign valid = ~w_empty;
    assign dout  = w_empty ? '0 : w_head;
  end else begin : g_std
    logic                    r_valid;
    logic [OUTPUT_WIDTH-1:0] r_dout;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_valid <= 1'b0;
        r_dout  <= '0;
      end else begin
        r_valid <= w_rd_acc;
        if (w_rd_acc) r_dout <= w_head;
      end
    end

    assign valid = r_valid;
    assign dout  = r_dout;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: FWFT/STANDARD at equal width, 16->8 and 8->16 packing.
module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Group A: 16/16 FWFT and STANDARD sharing stimulus
  logic        a_wr, a_rd;
  logic [15:0] a_din;
  logic        f_valid, f_full, f_empty, s_valid, s_full, s_empty;
  logic [15:0] f_dout, s_dout;
  logic [4:0]  f_wcnt, f_rcnt, f_wsp, f_rsp, s_wcnt, s_rcnt, s_wsp, s_rsp;

  // Group B: 16 -> 8
  logic        b_wr, b_rd;
  logic [15:0] b_din;
  logic        bl_valid, bl_full, bl_empty, bm_valid, bm_full, bm_empty;
  logic [7:0]  bl_dout, bm_dout;
  logic [4:0]  bl_wcnt, bl_wsp, bm_wcnt, bm_wsp;
  logic [5:0]  bl_rcnt, bl_rsp, bm_rcnt, bm_rsp;

  // Group C: 8 -> 16
  logic        c_wr, c_rd;
  logic [7:0]  c_din;
  logic        cl_valid, cl_full, cl_empty, cm_valid, cm_full, cm_empty;
  logic [15:0] cl_dout, cm_dout;
  logic [5:0]  cl_wcnt, cl_wsp, cm_wcnt, cm_wsp;
  logic [4:0]  cl_rcnt, cl_rsp, cm_rcnt, cm_rsp;

  sync_fifo u_fwft (
    .clock(clk), .reset(rst), .wr_en(a_wr), .din(a_din), .rd_en(a_rd),
    .valid(f_valid), .dout(f_dout), .full(f_full), .empty(f_empty),
    .wr_data_count(f_wcnt), .rd_data_count(f_rcnt),
    .wr_data_space(f_wsp), .rd_data_space(f_rsp)
  );

  sync_fifo #(.MODE("STANDARD")) u_std (
    .clock(clk), .reset(rst), .wr_en(a_wr), .din(a_din), .rd_en(a_rd),
    .valid(s_valid), .dout(s_dout), .full(s_full), .empty(s_empty),
    .wr_data_count(s_wcnt), .rd_data_count(s_rcnt),
    .wr_data_space(s_wsp), .rd_data_space(s_rsp)
  );

  sync_fifo #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(8), .WR_DEPTH(16), .RD_DEPTH(32),
              .DIRECTION("LSB")) u_w2n_lsb (
    .clock(clk), .reset(rst), .wr_en(b_wr), .din(b_din), .rd_en(b_rd),
    .valid(bl_valid), .dout(bl_dout), .full(bl_full), .empty(bl_empty),
    .wr_data_count(bl_wcnt), .rd_data_count(bl_rcnt),
    .wr_data_space(bl_wsp), .rd_data_space(bl_rsp)
  );

  sync_fifo #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(8), .WR_DEPTH(16), .RD_DEPTH(32),
              .DIRECTION("MSB")) u_w2n_msb (
    .clock(clk), .reset(rst), .wr_en(b_wr), .din(b_din), .rd_en(b_rd),
    .valid(bm_valid), .dout(bm_dout), .full(bm_full), .empty(bm_empty),
    .wr_data_count(bm_wcnt), .rd_data_count(bm_rcnt),
    .wr_data_space(bm_wsp), .rd_data_space(bm_rsp)
  );

  sync_fifo #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(16), .WR_DEPTH(32), .RD_DEPTH(16),
              .DIRECTION("LSB")) u_n2w_lsb (
    .clock(clk), .reset(rst), .wr_en(c_wr), .din(c_din), .rd_en(c_rd),
    .valid(cl_valid), .dout(cl_dout), .full(cl_full), .empty(cl_empty),
    .wr_data_count(cl_wcnt), .rd_data_count(cl_rcnt),
    .wr_data_space(cl_wsp), .rd_data_space(cl_rsp)
  );

  sync_fifo #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(16), .WR_DEPTH(32), .RD_DEPTH(16),
              .DIRECTION("MSB")) u_n2w_msb (
    .clock(clk), .reset(rst), .wr_en(c_wr), .din(c_din), .rd_en(c_rd),
    .valid(cm_valid), .dout(cm_dout), .full(cm_full), .empty(cm_empty),
    .wr_data_count(cm_wcnt), .rd_data_count(cm_rcnt),
    .wr_data_space(cm_wsp), .rd_data_space(cm_rsp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_w;

    rst = 1'b1;
    a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
    b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
    c_wr = 1'b0; c_rd = 1'b0; c_din = '0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_empty", f_empty, 1);
    chk("rst_full", f_full, 0);
    chk("rst_wsp", f_wsp, 16);
    chk("rst_rsp", f_rsp, 16);
    chk("rst_valid", f_valid, 0);
    chk("rst_dout", f_dout, 0);
    chk("rst_std_valid", s_valid, 0);
    chk("rst_std_dout", s_dout, 0);
    chk("rst_w2n_rsp", bl_rsp, 32);
    chk("rst_n2w_wsp", cl_wsp, 32);

    // fill to full
    for (int i = 0; i < 16; i++) begin
      a_wr  = 1'b1;
      a_din = 16'h0123 + 16'(i) * 16'h0101;
      tick();
      chk("fill_wcnt", f_wcnt, i + 1);
    end
    chk("fill_full", f_full, 1);
    chk("fill_wsp", f_wsp, 0);
    chk("fill_rcnt", f_rcnt, 16);
    a_din = 16'hAAAA;
    tick();
    a_wr = 1'b0;
    chk("drop_wcnt", f_wcnt, 16);
    chk("drop_full", f_full, 1);
    chk("std_idle_valid", s_valid, 0);

    // drain with rd_en held
    a_rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_w = 16'h0123 + 16'(i) * 16'h0101;
      chk("fwft_valid", f_valid, 1);
      chk("fwft_dout", f_dout, exp_w);
      tick();
      chk("std_valid", s_valid, 1);
      chk("std_dout", s_dout, exp_w);
      chk("drain_rcnt", f_rcnt, 15 - i);
    end
    chk("drain_empty", f_empty, 1);
    chk("drain_valid", f_valid, 0);
    chk("drain_last", s_dout, 16'h1032);
    tick();
    a_rd = 1'b0;
    chk("rd_empty_std_valid", s_valid, 0);
    chk("rd_empty_std_hold", s_dout, 16'h1032);
    chk("rd_empty_wcnt", f_wcnt, 0);

    // single STANDARD read pulse
    a_wr = 1'b1; a_din = 16'h5A5A;
    tick();
    a_wr = 1'b0;
    chk("fwft_first_valid", f_valid, 1);
    chk("fwft_first_dout", f_dout, 16'h5A5A);
    chk("std_no_read_valid", s_valid, 0);
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    chk("std_pulse_valid", s_valid, 1);
    chk("std_pulse_dout", s_dout, 16'h5A5A);
    tick();
    chk("std_pulse_end", s_valid, 0);
    chk("std_pulse_hold", s_dout, 16'h5A5A);

    // simultaneous read and write at count 8
    for (int i = 0; i < 8; i++) begin
      a_wr = 1'b1; a_din = 16'h1000 + 16'(i);
      tick();
    end
    chk("sim_pre_cnt", f_wcnt, 8);
    chk("sim_pre_dout", f_dout, 16'h1000);
    a_rd = 1'b1; a_din = 16'h2000;
    tick();
    chk("sim_wcnt", f_wcnt, 8);
    chk("sim_rcnt", f_rcnt, 8);
    chk("sim_dout", f_dout, 16'h1001);
    chk("sim_std_dout", s_dout, 16'h1000);

    // reset mid-stream
    a_wr = 1'b0; a_rd = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_empty", f_empty, 1);
    chk("mrst_wcnt", f_wcnt, 0);
    chk("mrst_wsp", f_wsp, 16);
    chk("mrst_rsp", f_rsp, 16);
    chk("mrst_valid", f_valid, 0);
    chk("mrst_dout", f_dout, 0);
    chk("mrst_std_valid", s_valid, 0);
    chk("mrst_std_dout", s_dout, 0);

    // 16 -> 8 split
    b_wr = 1'b1; b_din = 16'h0123;
    tick();
    b_wr = 1'b0;
    chk("w2n_rcnt", bl_rcnt, 2);
    chk("w2n_wcnt", bl_wcnt, 1);
    chk("w2n_rsp", bl_rsp, 30);
    chk("w2n_lsb_d0", bl_dout, 8'h23);
    chk("w2n_msb_d0", bm_dout, 8'h01);
    b_rd = 1'b1;
    tick();
    chk("w2n_lsb_d1", bl_dout, 8'h01);
    chk("w2n_msb_d1", bm_dout, 8'h23);
    chk("w2n_rcnt1", bl_rcnt, 1);
    chk("w2n_wcnt_ceil", bl_wcnt, 1);
    tick();
    b_rd = 1'b0;
    chk("w2n_empty", bl_empty, 1);
    chk("w2n_wcnt0", bl_wcnt, 0);

    // 8 -> 16 pack
    c_wr = 1'b1; c_din = 8'h23;
    tick();
    chk("n2w_partial_empty", cl_empty, 1);
    chk("n2w_partial_wcnt", cl_wcnt, 1);
    chk("n2w_partial_dout", cl_dout, 0);
    c_din = 8'h01;
    tick();
    c_wr = 1'b0;
    chk("n2w_rcnt", cl_rcnt, 1);
    chk("n2w_rsp", cl_rsp, 15);
    chk("n2w_lsb_dout", cl_dout, 16'h0123);
    chk("n2w_msb_dout", cm_dout, 16'h2301);
    chk("n2w_valid", cl_valid, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
